fpu_op_dispatch: RTL and testbench

Parametrised operation dispatcher for the coprocessor FPU. It accepts an operand pair and an op code over stb/ack handshakes, latches the op code per transaction, and forwards the operands to one of `NUM_UNITS` arithmetic units (adder, multiplier, divider, …). It returns the unit's result with an op tag and an error flag. Unselected units are held in reset, and an optional watchdog recovers from hung units.

---
 rtl/fpu_op_dispatch.sv | 218 +++++++++++++++++++++
 tb/tb_fpu_op_dispatch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_dispatch.sv
// Operand/op-code dispatcher that routes an operand pair to one of NUM_UNITS FPU units.
// Optional hung-unit watchdog is enabled by defining FPU_DISPATCH_TIMEOUT_EN.
module fpu_op_dispatch #(
  parameter int WIDTH = 32,
  parameter int NUM_UNITS = 3,
  parameter int OP_W = 2,
  parameter logic [WIDTH-1:0] NAN_VALUE = 32'h7FC00000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           input_a,
  input  logic                       input_a_stb,
  output logic                       input_a_ack,
  input  logic [OP_W-1:0]            op_sel,
  input  logic [WIDTH-1:0]           input_b,
  input  logic                       input_b_stb,
  output logic                       input_b_ack,
  output logic [WIDTH-1:0]           output_z,
  output logic                       output_z_stb,
  input  logic                       output_z_ack,
  output logic [OP_W-1:0]            output_op,
  output logic                       output_err,
  output logic [WIDTH-1:0]           unit_a,
  output logic [WIDTH-1:0]           unit_b,
  output logic [NUM_UNITS-1:0]       unit_a_stb,
  output logic [NUM_UNITS-1:0]       unit_b_stb,
  input  logic [NUM_UNITS-1:0]       unit_a_ack,
  input  logic [NUM_UNITS-1:0]       unit_b_ack,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_z,
  input  logic [NUM_UNITS-1:0]       unit_z_stb,
  output logic [NUM_UNITS-1:0]       unit_z_ack,
  output logic [NUM_UNITS-1:0]       unit_rst
);

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    ISSUE_A = 3'd2,
    ISSUE_B = 3'd3,
    WAIT_Z  = 3'd4,
    PUT_Z   = 3'd5
  } state_t;

  localparam logic [NUM_UNITS-1:0] NO_UNITS = {NUM_UNITS{1'b0}};

  state_t               state;
  state_t               next_state;
  logic [OP_W-1:0]      op;
  logic                 op_valid;
  logic [NUM_UNITS-1:0] unit_mask;
  logic                 a_hs, b_hs, ua_hs, ub_hs, uz_hs, z_hs;
  logic                 waiting, expire, timeout_fire;
  logic                 load_z, load_err;
  logic [WIDTH-1:0]     load_val, sel_z;

  // An out-of-range code decodes to no unit, which doubles as the invalid-op test.
  function automatic logic [NUM_UNITS-1:0] onehot(input logic [OP_W-1:0] code);
    logic [NUM_UNITS-1:0] res;
    res = {NUM_UNITS{1'b0}};
    for (int k = 0; k < NUM_UNITS; k++) begin
      res[k] = (code == OP_W'(k));
    end
    return res;
  endfunction

  assign a_hs    = input_a_ack & input_a_stb;
  assign b_hs    = input_b_ack & input_b_stb;
  assign ua_hs   = |(unit_a_stb & unit_a_ack);
  assign ub_hs   = |(unit_b_stb & unit_b_ack);
  assign uz_hs   = |(unit_z_ack & unit_z_stb);
  assign z_hs    = output_z_stb & output_z_ack;
  assign waiting = (state == ISSUE_A) || (state == ISSUE_B) || (state == WAIT_Z);

`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timer;

  // Watchdog: cleared while collecting B, counts every cycle spent on the unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= {CNT_W{1'b0}};
    end else if (state == GET_B) begin
      timer <= {CNT_W{1'b0}};
    end else if (waiting) begin
      timer <= timer + CNT_W'(1);
    end
  end

  assign expire = waiting && (timer == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // Result slice of the selected unit.
  always_comb begin
    sel_z = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_UNITS; k++) begin
      sel_z = (op == OP_W'(k)) ? unit_z[k*WIDTH +: WIDTH] : sel_z;
    end
  end

  // Next-state logic; a unit handshake wins over a simultaneous watchdog expiry.
  always_comb begin
    next_state   = state;
    timeout_fire = 1'b0;
    load_z       = 1'b0;
    load_val     = NAN_VALUE;
    load_err     = 1'b1;
    case (state)
      GET_A: begin
        if (a_hs) next_state = GET_B;
        else      next_state = state;
      end
      GET_B: begin
        if (b_hs && op_valid) begin
          next_state = ISSUE_A;
        end else if (b_hs) begin
          next_state = PUT_Z;
          load_z     = 1'b1;
        end else begin
          next_state = state;
        end
      end
      ISSUE_A: begin
        if (ua_hs) begin
          next_state = ISSUE_B;
        end else if (expire) begin
          next_state   = PUT_Z;
          timeout_fire = 1'b1;
          load_z       = 1'b1;
        end else begin
          next_state = state;
        end
      end
      ISSUE_B: begin
        if (ub_hs) begin
          next_state = WAIT_Z;
        end else if (expire) begin
          next_state   = PUT_Z;
          timeout_fire = 1'b1;
          load_z       = 1'b1;
        end else begin
          next_state = state;
        end
      end
      WAIT_Z: begin
        if (uz_hs) begin
          next_state = PUT_Z;
          load_z     = 1'b1;
          load_val   = sel_z;
          load_err   = 1'b0;
        end else if (expire) begin
          next_state   = PUT_Z;
          timeout_fire = 1'b1;
          load_z       = 1'b1;
        end else begin
          next_state = state;
        end
      end
      PUT_Z: begin
        if (z_hs) next_state = GET_A;
        else      next_state = state;
      end
      default: next_state = GET_A;
    endcase
  end

  // State plus every output, all registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GET_A;
      op           <= {OP_W{1'b0}};
      op_valid     <= 1'b0;
      unit_mask    <= {NUM_UNITS{1'b1}};
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= {WIDTH{1'b0}};
      output_op    <= {OP_W{1'b0}};
      output_err   <= 1'b0;
      unit_a       <= {WIDTH{1'b0}};
      unit_b       <= {WIDTH{1'b0}};
      unit_a_stb   <= NO_UNITS;
      unit_b_stb   <= NO_UNITS;
      unit_z_ack   <= NO_UNITS;
      unit_rst     <= {NUM_UNITS{1'b1}};
    end else begin
      state        <= next_state;
      input_a_ack  <= (next_state == GET_A);
      input_b_ack  <= (next_state == GET_B);
      output_z_stb <= (next_state == PUT_Z);
      unit_a_stb   <= (next_state == ISSUE_A) ? onehot(op) : NO_UNITS;
      unit_b_stb   <= (next_state == ISSUE_B) ? onehot(op) : NO_UNITS;
      unit_z_ack   <= (next_state == WAIT_Z)  ? onehot(op) : NO_UNITS;
      if (a_hs) begin
        unit_a    <= input_a;
        op        <= op_sel;
        op_valid  <= |onehot(op_sel);
        unit_mask <= ~onehot(op_sel);
        unit_rst  <= ~onehot(op_sel);
      end else if (timeout_fire) begin
        unit_rst <= unit_mask | onehot(op);
      end else begin
        unit_rst <= unit_mask;
      end
      if (b_hs) begin
        unit_b <= input_b;
      end
      if (load_z) begin
        output_z   <= load_val;
        output_err <= load_err;
        output_op  <= op;
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Directed bench for fpu_op_dispatch with a transaction-level result model.
// The watchdog scenario runs only when FPU_DISPATCH_TIMEOUT_EN is defined.
module tb_fpu_op_dispatch;

  localparam int W = 32;
  localparam int N = 3;
  localparam int OW = 2;
  localparam int TMO = 16;
  localparam logic [31:0] NAN = 32'h7FC00000;
  localparam logic [31:0] Z0 = 32'h40400000;
  localparam logic [31:0] Z1 = 32'h11112222;
  localparam logic [31:0] Z2 = 32'h33334444;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] input_a = 32'h0, input_b = 32'h0;
  logic input_a_stb = 1'b0, input_b_stb = 1'b0, output_z_ack = 1'b0;
  logic input_a_ack, input_b_ack, output_z_stb, output_err;
  logic [OW-1:0] op_sel = 2'd0;
  logic [OW-1:0] output_op;
  logic [W-1:0] output_z, unit_a, unit_b;
  logic [N-1:0] unit_a_stb, unit_b_stb, unit_z_ack, unit_rst;
  logic [N-1:0] unit_a_ack = 3'b111, unit_b_ack = 3'b111, unit_z_stb = 3'b111;
  logic [N*W-1:0] unit_z;

  assign unit_z = {Z2, Z1, Z0};

  fpu_op_dispatch #(.WIDTH(W), .NUM_UNITS(N), .OP_W(OW), .NAN_VALUE(NAN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack), .op_sel(op_sel),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
    .output_op(output_op), .output_err(output_err),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_a_stb(unit_a_stb), .unit_b_stb(unit_b_stb),
    .unit_a_ack(unit_a_ack), .unit_b_ack(unit_b_ack),
    .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
    .unit_rst(unit_rst)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] unit_result(input logic [1:0] code);
    case (code)
      2'd0:    return Z0;
      2'd1:    return Z1;
      2'd2:    return Z2;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Transaction-level model: expected results queue, expected unit resets, current op.
  typedef struct {
    logic [31:0] z;
    logic [1:0]  op;
    logic        err;
  } res_t;

  res_t exp_q[$];
  logic [N-1:0] exp_rst = 3'b111;
  logic [1:0]   cur_op = 2'd0;
  logic         cur_valid = 1'b0;
  logic [31:0]  cur_a = 32'h0, cur_b = 32'h0;
  logic         live = 1'b0;
  logic         hang_mode = 1'b0;
  int           pulse_cnt = 0;
  logic [N-1:0] stb_seen = 3'b000;
  logic [N-1:0] sel_mask;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_rst   = 3'b111;
      cur_valid = 1'b0;
      live      = 1'b1;
    end else if (live) begin
      sel_mask = cur_valid ? (3'b001 << cur_op) : 3'b000;
      if (!hang_mode) check("unit_rst", {29'b0, unit_rst}, {29'b0, exp_rst});
      check("unit_sel", {29'b0, (unit_a_stb | unit_b_stb | unit_z_ack) & ~sel_mask}, 32'h0);
      if (output_z_stb) begin
        if (exp_q.size() == 0) begin
          check("z_unexpected", {31'b0, output_z_stb}, 32'h0);
        end else begin
          check("z_value", output_z, exp_q[0].z);
          check("z_op", {30'b0, output_op}, {30'b0, exp_q[0].op});
          check("z_err", {31'b0, output_err}, {31'b0, exp_q[0].err});
        end
      end
      stb_seen = stb_seen | unit_a_stb | unit_b_stb | unit_z_ack;
      if (hang_mode && unit_rst[1]) pulse_cnt++;
      // Events that complete at the coming edge.
      if (input_a_stb && input_a_ack) begin
        cur_op    = op_sel;
        cur_a     = input_a;
        cur_valid = (op_sel < 2'd3);
        exp_rst   = cur_valid ? ~(3'b001 << op_sel) : 3'b111;
      end
      if (input_b_stb && input_b_ack) begin
        cur_b = input_b;
        if (!cur_valid) exp_q.push_back('{NAN, cur_op, 1'b1});
      end
      if (|(unit_a_stb & unit_a_ack)) check("unit_a_operand", unit_a, cur_a);
      if (|(unit_b_stb & unit_b_ack)) check("unit_b_operand", unit_b, cur_b);
      if (|(unit_z_ack & unit_z_stb)) exp_q.push_back('{unit_result(cur_op), cur_op, 1'b0});
      if (output_z_stb && output_z_ack && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  int a_cyc, b_cyc, z_cyc;
  logic [31:0] got_z;
  logic [1:0]  got_op;
  logic        got_err;

  task automatic send_a(input logic [31:0] a, input logic [1:0] op);
    int n = 0;
    input_a = a; op_sel = op; input_a_stb = 1'b1;
    @(negedge clk);
    while (!input_a_ack && n < 50) begin n++; @(negedge clk); end
    if (!input_a_ack) check("a_ack_timeout", {31'b0, input_a_ack}, 32'h1);
    a_cyc = cyc;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] b, input logic [1:0] op_late);
    int n = 0;
    op_sel = op_late; input_b = b; input_b_stb = 1'b1;
    @(negedge clk);
    while (!input_b_ack && n < 50) begin n++; @(negedge clk); end
    if (!input_b_ack) check("b_ack_timeout", {31'b0, input_b_ack}, 32'h1);
    b_cyc = cyc;
    @(posedge clk); #1;
    input_b_stb = 1'b0;
  endtask

  task automatic get_z(input int hold);
    int n = 0;
    @(negedge clk);
    while (!output_z_stb && n < 100) begin n++; @(negedge clk); end
    if (!output_z_stb) check("z_stb_timeout", {31'b0, output_z_stb}, 32'h1);
    z_cyc = cyc; got_z = output_z; got_op = output_op; got_err = output_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_z_stb", {31'b0, output_z_stb}, 32'h1);
      check("bp_z_stable", output_z, got_z);
      check("bp_a_ack_low", {31'b0, input_a_ack}, 32'h0);
    end
    @(posedge clk); #1; output_z_ack = 1'b1;
    @(posedge clk); #1; output_z_ack = 1'b0;
    @(negedge clk);
    check("a_ack_after_z", {31'b0, input_a_ack}, 32'h1);
    check("z_stb_after_z", {31'b0, output_z_stb}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [1:0] op_late, input int hold);
    stb_seen = 3'b000;
    send_a(a, op);
    send_b(b, op_late);
    get_z(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ack", {31'b0, input_a_ack}, 32'h0);
    check("rst_b_ack", {31'b0, input_b_ack}, 32'h0);
    check("rst_z_stb", {31'b0, output_z_stb}, 32'h0);
    check("rst_z", output_z, 32'h0);
    check("rst_op", {30'b0, output_op}, 32'h0);
    check("rst_err", {31'b0, output_err}, 32'h0);
    check("rst_unit_a", unit_a, 32'h0);
    check("rst_unit_b", unit_b, 32'h0);
    check("rst_unit_hs", {29'b0, unit_a_stb | unit_b_stb | unit_z_ack}, 32'h0);
    check("rst_unit_rst", {29'b0, unit_rst}, 32'h7);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_a_ack", {31'b0, input_a_ack}, 32'h1);

    // Add on unit 0, zero-wait units.
    do_txn(32'h3F800000, 32'h40000000, 2'd0, 2'd0, 0);
    check("add_z", got_z, 32'h40400000);
    check("add_op", {30'b0, got_op}, 32'h0);
    check("add_err", {31'b0, got_err}, 32'h0);
    check("add_latency", z_cyc - a_cyc, 32'd5);
    check("add_unit_rst", {29'b0, unit_rst}, 32'h6);
    check("add_stb_seen", {29'b0, stb_seen}, 32'h1);

    // Op code changes after A handshake: unit 2 still used.
    do_txn(32'h00000005, 32'h00000007, 2'd2, 2'd1, 0);
    check("late_op_z", got_z, 32'h33334444);
    check("late_op_op", {30'b0, got_op}, 32'h2);
    check("late_op_stb_seen", {29'b0, stb_seen}, 32'h4);
    check("late_op_unit_rst", {29'b0, unit_rst}, 32'h3);

    // Invalid op code.
    do_txn(32'h12345678, 32'h9ABCDEF0, 2'd3, 2'd3, 0);
    check("inv_z", got_z, 32'h7FC00000);
    check("inv_err", {31'b0, got_err}, 32'h1);
    check("inv_op", {30'b0, got_op}, 32'h3);
    check("inv_latency", z_cyc - b_cyc, 32'd1);
    check("inv_stb_seen", {29'b0, stb_seen}, 32'h0);
    check("inv_unit_rst", {29'b0, unit_rst}, 32'h7);

    // Backpressure on the result.
    do_txn(32'hAAAA5555, 32'h5555AAAA, 2'd1, 2'd1, 10);
    check("bp_z", got_z, 32'h11112222);
    check("bp_op", {30'b0, got_op}, 32'h1);
    check("bp_err", {31'b0, got_err}, 32'h0);

    // Reset while waiting on a silent unit 2.
    unit_z_stb = 3'b011;
    send_a(32'h00000001, 2'd2);
    send_b(32'h00000002, 2'd2);
    repeat (5) @(posedge clk);
    #1;
    check("hang_z_ack", {29'b0, unit_z_ack}, 32'h4);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    unit_z_stb = 3'b111;
    check("midrst_unit_rst", {29'b0, unit_rst}, 32'h7);
    check("midrst_z_stb", {31'b0, output_z_stb}, 32'h0);
    @(posedge clk); #1;
    check("midrst_a_ack", {31'b0, input_a_ack}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", {31'b0, output_z_stb}, 32'h0);
    end

    // Recovery after reset.
    do_txn(32'h3F800000, 32'h40000000, 2'd0, 2'd0, 0);
    check("recover_z", got_z, 32'h40400000);
    check("recover_op", {30'b0, got_op}, 32'h0);

`ifdef FPU_DISPATCH_TIMEOUT_EN
    // Unit 1 never answers: watchdog returns NaN with error.
    unit_z_stb = 3'b101;
    stb_seen = 3'b000;
    send_a(32'h0000000A, 2'd1);
    hang_mode = 1'b1;
    pulse_cnt = 0;
    send_b(32'h0000000B, 2'd1);
    exp_q.push_back('{NAN, 2'd1, 1'b1});
    get_z(0);
    check("tmo_z", got_z, 32'h7FC00000);
    check("tmo_err", {31'b0, got_err}, 32'h1);
    check("tmo_op", {30'b0, got_op}, 32'h1);
    check("tmo_latency_window", {31'b0, (z_cyc - b_cyc >= TMO) && (z_cyc - b_cyc <= TMO + 2)}, 32'h1);
    check("tmo_pulse_count", pulse_cnt, 32'd1);
    check("tmo_unit_rst_after", {29'b0, unit_rst}, 32'h5);
    hang_mode = 1'b0;
    unit_z_stb = 3'b111;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
